// File: rtl/matrix_rx_loader.sv
// Parses a UART byte stream (size N, N*N A elements, N*N B elements) into operand memory writes, then pulses start.
// Latency: write 1 cycle after rx_valid, start 2 cycles after the last B byte; busy/n_out/err 1 cycle after the size byte.
// No backpressure: bytes arriving in WAIT_DONE are dropped; optional inter-byte timeout under LOADER_TIMEOUT_EN.
module matrix_rx_loader #(
    parameter int MAX_N          = 10,
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 7,
    parameter int N_W            = 4,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              done,
    output logic              a_we,
    output logic              b_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [N_W-1:0]    n_out,
    output logic              start,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = ADDR_W + 1;

    if (((1 << ADDR_W) < MAX_N * MAX_N) || ((1 << N_W) <= MAX_N) || (TIMEOUT_CYCLES < 2)) begin : g_param_check
        $error("matrix_rx_loader: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_START,
        S_WAIT_DONE
    } state_t;

    state_t              state, state_d;
    logic [ADDR_W-1:0]   cnt, cnt_d;
    logic [CNT_W-1:0]    total, total_d;
    logic                a_we_d, b_we_d, start_d, err_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [N_W-1:0]      n_d;
    logic                size_ok;
    logic                last_elem;
    logic                tmo_hit;

    assign size_ok   = (rx_data != '0) && (rx_data <= DATA_W'(MAX_N));
    assign last_elem = (CNT_W'(cnt) + CNT_W'(1)) == total;

`ifdef LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    // tmo_cnt holds the number of cycles elapsed since the most recent byte
    logic [TMO_W-1:0] tmo_cnt;
    logic             loading;

    assign loading = (state == S_LOAD_A) || (state == S_LOAD_B);
    assign tmo_hit = loading && !rx_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (tmo_hit || (!loading && !rx_valid)) begin
            tmo_cnt <= '0;
        end else if (rx_valid) begin
            tmo_cnt <= TMO_W'(1);
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        total_d = total;
        a_we_d  = 1'b0;
        b_we_d  = 1'b0;
        start_d = 1'b0;
        err_d   = 1'b0;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        n_d     = n_out;
        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    if (size_ok) begin
                        n_d     = N_W'(rx_data);
                        total_d = CNT_W'(rx_data) * CNT_W'(rx_data);
                        cnt_d   = '0;
                        state_d = S_LOAD_A;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD_A, S_LOAD_B: begin
                if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (rx_valid) begin
                    a_we_d  = (state == S_LOAD_A);
                    b_we_d  = (state == S_LOAD_B);
                    addr_d  = cnt;
                    wdata_d = rx_data;
                    if (last_elem) begin
                        cnt_d   = '0;
                        state_d = (state == S_LOAD_A) ? S_LOAD_B : S_START;
                    end else begin
                        cnt_d = cnt + ADDR_W'(1);
                    end
                end
            end
            S_START: begin
                start_d = 1'b1;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            total     <= '0;
            a_we      <= 1'b0;
            b_we      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            n_out     <= '0;
            start     <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            total     <= total_d;
            a_we      <= a_we_d;
            b_we      <= b_we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            n_out     <= n_d;
            start     <= start_d;
            busy      <= (state_d != S_IDLE);
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_matrix_rx_loader.sv
// Directed bench for matrix_rx_loader: a frame-level reference model predicts every output each cycle,
// plus literal checks on write counts, start/err timing and n_out.
module tb_matrix_rx_loader;

    localparam int MAX_N = 10;
    localparam int TMO   = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       done;
    logic       a_we, b_we, start, busy, err;
    logic [6:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [3:0] n_out;

    matrix_rx_loader #(
        .MAX_N(MAX_N), .DATA_W(8), .ADDR_W(7), .N_W(4), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .done(done),
        .a_we(a_we), .b_we(b_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .n_out(n_out), .start(start), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    // Frame-level reference: phase 0 idle, 1 loading A, 2 loading B, 3 start due, 4 waiting for done
    int   m_phase, m_n, m_total, m_idx;
    int   last_rx_cyc;
    logic e_awe, e_bwe, e_start, e_err, e_busy;
    logic [6:0] e_addr;
    logic [7:0] e_wdata;
    logic [3:0] e_n;

    int a_cnt, b_cnt, start_cnt, err_cnt, start_cyc, err_cyc;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_n = 0; m_total = 0; m_idx = 0;
        e_awe = 0; e_bwe = 0; e_start = 0; e_err = 0; e_busy = 0;
        e_addr = '0; e_wdata = '0; e_n = '0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic dn);
        e_awe = 0; e_bwe = 0; e_start = 0; e_err = 0;
        case (m_phase)
            0: if (v) begin
                if (int'(d) >= 1 && int'(d) <= MAX_N) begin
                    m_n = int'(d); m_total = m_n * m_n; m_idx = 0; m_phase = 1;
                end else begin
                    e_err = 1;
                end
            end
            1, 2: if (v) begin
                if (m_phase == 1) e_awe = 1; else e_bwe = 1;
                e_addr  = 7'(m_idx);
                e_wdata = d;
                m_idx++;
                if (m_idx == m_total) begin
                    m_idx = 0;
                    m_phase++;
                end
            end
`ifdef LOADER_TIMEOUT_EN
            else if (cyc + 1 - last_rx_cyc == TMO) begin
                e_err = 1;
                m_phase = 0;
            end
`endif
            3: begin
                e_start = 1;
                m_phase = 4;
            end
            4: if (dn) m_phase = 0;
            default: m_phase = 0;
        endcase
        e_busy = (m_phase != 0);
        e_n    = 4'(m_n);
    endtask

    always @(negedge clk) begin
        chk("a_we", a_we, e_awe);
        chk("b_we", b_we, e_bwe);
        chk("start", start, e_start);
        chk("err", err, e_err);
        chk("busy", busy, e_busy);
        chk("n_out", n_out, e_n);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        if (a_we) a_cnt++;
        if (b_we) b_cnt++;
        if (start) begin start_cnt++; start_cyc = cyc; end
        if (err) begin err_cnt++; err_cyc = cyc; end
    end

    task automatic tick(input logic v, input logic [7:0] d, input logic dn);
        @(negedge clk);
        #1;
        rx_valid = v; rx_data = d; done = dn;
        model_step(v, d, dn);
        if (v) last_rx_cyc = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
    endtask

    task automatic clr_counts();
        a_cnt = 0; b_cnt = 0; start_cnt = 0; err_cnt = 0; start_cyc = -1; err_cyc = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0; done = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_frame(input int n, input int a_base, input int b_base);
        tick(1'b1, 8'(n), 1'b0);
        for (int i = 0; i < n * n; i++) tick(1'b1, 8'(a_base + i), 1'b0);
        for (int i = 0; i < n * n; i++) tick(1'b1, 8'(b_base + i), 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0; done = 1'b0;
        model_reset();
        clr_counts();
        last_rx_cyc = 0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_n_out", n_out, 0);

        // Full 10x10 frame, back-to-back bytes
        clr_counts();
        send_frame(10, 0, 100);
        idle(3);
        chk("t1_a_writes", a_cnt, 100);
        chk("t1_b_writes", b_cnt, 100);
        chk("t1_start_count", start_cnt, 1);
        chk("t1_start_delay", start_cyc - last_rx_cyc, 2);
        chk("t1_n_out", n_out, 10);
        chk("t1_busy_waiting", busy, 1);
        tick(1'b0, 8'h00, 1'b1);
        idle(1);
        chk("t1_busy_after_done", busy, 0);

        // Rejected sizes from reset, then a 2x2 frame
        do_reset();
        clr_counts();
        tick(1'b1, 8'd0, 1'b0);
        tick(1'b1, 8'd11, 1'b0);
        idle(2);
        chk("t2_err_count", err_cnt, 2);
        chk("t2_no_writes", a_cnt + b_cnt, 0);
        chk("t2_busy", busy, 0);
        chk("t2_n_out", n_out, 0);
        send_frame(2, 8'h10, 8'h20);
        idle(3);
        chk("t2_writes", a_cnt + b_cnt, 8);
        chk("t2_start", start_cnt, 1);
        chk("t2_n_out_after", n_out, 2);
        tick(1'b0, 8'h00, 1'b1);
        idle(1);

        // N=1 on consecutive cycles
        clr_counts();
        tick(1'b1, 8'd1, 1'b0);
        tick(1'b1, 8'hAA, 1'b0);
        tick(1'b1, 8'h55, 1'b0);
        idle(1);
        chk("t3_b_wdata", mem_wdata, 8'h55);
        chk("t3_b_addr", mem_addr, 0);
        idle(2);
        chk("t3_writes", a_cnt + b_cnt, 2);
        chk("t3_start_delay", start_cyc - last_rx_cyc, 2);
        tick(1'b0, 8'h00, 1'b1);
        idle(1);

        // Bytes in WAIT_DONE dropped, including one coincident with done; stray done while loading ignored
        clr_counts();
        send_frame(2, 8'h30, 8'h40);
        idle(2);
        tick(1'b1, 8'h01, 1'b0);
        tick(1'b1, 8'h02, 1'b0);
        tick(1'b1, 8'h03, 1'b1);
        tick(1'b1, 8'd3, 1'b0);
        tick(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 9; i++) tick(1'b1, 8'(8'h50 + i), 1'b0);
        for (int i = 0; i < 9; i++) tick(1'b1, 8'(8'h60 + i), 1'b0);
        idle(3);
        chk("t4_a_writes", a_cnt, 4 + 9);
        chk("t4_b_writes", b_cnt, 4 + 9);
        chk("t4_n_out", n_out, 3);
        chk("t4_start_count", start_cnt, 2);
        tick(1'b0, 8'h00, 1'b1);
        idle(1);

        // Reset in the middle of loading A
        clr_counts();
        tick(1'b1, 8'd10, 1'b0);
        for (int i = 0; i < 37; i++) tick(1'b1, 8'(i), 1'b0);
        do_reset();
        chk("t5_busy", busy, 0);
        chk("t5_n_out", n_out, 0);
        chk("t5_addr", mem_addr, 0);
        send_frame(2, 8'h70, 8'h80);
        idle(3);
        chk("t5_writes", a_cnt + b_cnt, 37 + 8);
        chk("t5_start", start_cnt, 1);
        tick(1'b0, 8'h00, 1'b1);
        idle(1);

`ifdef LOADER_TIMEOUT_EN
        clr_counts();
        tick(1'b1, 8'd3, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'h90 + i), 1'b0);
        idle(TMO + 5);
        chk("t6_err_count", err_cnt, 1);
        chk("t6_err_delay", err_cyc - last_rx_cyc, TMO);
        chk("t6_busy", busy, 0);
        chk("t6_n_out_kept", n_out, 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/matrix_rx_loader.md
# matrix_rx_loader

Upstream stage of the UART matrix multiplier. Consumes bytes delivered by the UART receiver and parses them as one frame: a size byte N, then N×N bytes of matrix A in row-major order, then N×N bytes of matrix B. It writes each element into the A or B operand memory, pulses `start` to the multiplier, and holds off further frames until the multiplier reports `done`.

## Interface
Parameters:
- `MAX_N`, 10: largest accepted matrix dimension.
- `DATA_W`, 8: element width. Must equal the UART byte width.
- `ADDR_W`, 7: operand memory address width. Must satisfy 2^ADDR_W ≥ MAX_N².
- `N_W`, 4: width of the captured size. Must satisfy 2^N_W > MAX_N.
- `TIMEOUT_CYCLES`, 5_000_000: inter-byte timeout. Used only when `LOADER_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx_valid` in 1: single-cycle strobe, one per received byte.
- `rx_data` in DATA_W: received byte. Valid only when `rx_valid`=1.
- `done` in 1: multiplier completion pulse.
- `a_we` out 1: write enable for matrix A memory.
- `b_we` out 1: write enable for matrix B memory.
- `mem_addr` out ADDR_W: element address, row*N+col. Shared by A and B.
- `mem_wdata` out DATA_W: element data.
- `n_out` out N_W: captured dimension, held stable from size capture until return to IDLE.
- `start` out 1: one-cycle pulse when both matrices are loaded.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: one-cycle pulse on a rejected size or on a timeout.

## Operation
- States: IDLE, LOAD_A, LOAD_B, START, WAIT_DONE.
- IDLE:
  - On `rx_valid`, `rx_data` is treated as the size byte.
  - If 1 ≤ value ≤ MAX_N: latch `n_out`, register `total` = N*N (ADDR_W+1 bits), clear the address counter, go to LOAD_A.
  - Otherwise: pulse `err` and stay in IDLE. `n_out` is unchanged.
- LOAD_A: each `rx_valid` writes `rx_data` to A at the current count, then the count increments. After write number `total`, clear the count and go to LOAD_B.
- LOAD_B: same as LOAD_A but writes to B. After the last write, go to START.
- START: assert `start` for exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE: `rx_valid` is ignored; those bytes are dropped and not buffered. `done` returns the block to IDLE.
- `done` in any state other than WAIT_DONE is ignored.
- N=1: one A byte, then one B byte, then `start`.
- The address counter never exceeds `total`-1. No wrap-around within a frame.
- Reset mid-frame: the frame is discarded. Memory contents are undefined to downstream until the next complete frame.

## Timing
- Reset values: `a_we`=0, `b_we`=0, `mem_addr`=0, `mem_wdata`=0, `n_out`=0, `start`=0, `busy`=0, `err`=0. State is IDLE, counter is 0.
- All outputs are registered.
- Write latency: `rx_valid` high in cycle k gives `a_we` or `b_we` high in cycle k+1, with `mem_addr` and `mem_wdata` valid in the same cycle. The enable stays high for one cycle only.
- Last B byte at cycle k: `b_we` at k+1, `start` at k+2, `busy` remains 1.
- Size byte at cycle k: `n_out` and `busy` update at k+1. An invalid size byte instead gives `err` at k+1.
- `done` at cycle k in WAIT_DONE: `busy`=0 at k+1, and a size byte is accepted from k+1.
- `rx_valid` in the same cycle as `done` in WAIT_DONE is dropped.
- Back-to-back `rx_valid` on consecutive cycles must be accepted without loss.

## Configuration
- `LOADER_TIMEOUT_EN` defined:
  - An inter-byte counter runs in LOAD_A and LOAD_B.
  - Every `rx_valid` clears it.
  - When it reaches `TIMEOUT_CYCLES`: pulse `err`, return to IDLE, clear the counter, keep `n_out`.
- `LOADER_TIMEOUT_EN` undefined: no counter logic is generated, and LOAD_A/LOAD_B wait indefinitely.

## Test plan
- Size 10, then 100 A bytes (0..99), then 100 B bytes (100..199). Expect 100 `a_we` with addr 0..99 and data 0..99; 100 `b_we` with addr 0..99 and data 100..199; a single `start` 2 cycles after the last `rx_valid`; `n_out`=10.
- Size 0, then size 11. Expect `err` pulse on each, no writes, `busy`=0, `n_out`=0. A following size 2 with 8 bytes then completes normally.
- Size 1, A=0xAA, B=0x55 on consecutive cycles. Expect `a_we` at addr 0 with 0xAA, `b_we` at addr 0 with 0x55, then `start`.
- Complete a size 2 frame, send 3 bytes in WAIT_DONE, then `done`, then a size 3 frame. Expect the 3 bytes dropped and the second frame written from addr 0 with `n_out`=3.
- Assert `rst` after 37 A bytes of a size 10 frame. Expect all outputs at reset values; a new size 2 frame is then accepted.
- With `LOADER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100: send size 3 and 4 bytes, then idle. Expect `err` exactly 100 cycles after the last `rx_valid`, then `busy`=0.
